// File: rtl/text_console_ctrl.sv
// ---------------------------------------------------------------------------
// text_console_ctrl
//
// Character-stream front end for the 80x60 text-mode display. ASCII bytes
// from the bus side are queued in a small FIFO. Control characters are
// interpreted, the cursor is tracked, and single-cycle character-cell write
// commands are emitted to the framebuffer.
//
// Optional feature macro: LINE_CLEAR_EN
//   defined   - every newline (LF or auto-wrap) clears the destination row
//   undefined - a newline only moves the cursor
//
// Ports:
//   i_clk_sys     system clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_wr_stb      one-cycle strobe, i_data_in holds a new byte
//   i_data_in     ASCII byte
//   o_full        FIFO holds FIFO_DEPTH entries
//   o_busy        FIFO non-empty or FSM not idle
//   o_overrun     sticky: strobe arrived while full
//   o_fb_we       framebuffer write enable, one cycle per cell
//   o_fb_addr     cell address = row*COLS + col
//   o_fb_data     glyph index
//   o_cursor_x    current column
//   o_cursor_y    current row
// ---------------------------------------------------------------------------
module text_console_ctrl #(
    parameter int COLS       = 80,
    parameter int ROWS       = 60,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        i_clk_sys,
    input  logic        i_rst,
    input  logic        i_wr_stb,
    input  logic [7:0]  i_data_in,
    output logic        o_full,
    output logic        o_busy,
    output logic        o_overrun,
    output logic        o_fb_we,
    output logic [12:0] o_fb_addr,
    output logic [6:0]  o_fb_data,
    output logic [6:0]  o_cursor_x,
    output logic [5:0]  o_cursor_y
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [12:0] COLS13    = 13'(COLS);
    localparam logic [12:0] LAST_CELL = 13'(COLS * ROWS - 1);
    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_POP, S_EXEC, S_CLEAR} state_t;
    typedef enum logic [2:0] {OP_NONE, OP_PRINT, OP_CR, OP_LF, OP_BS, OP_FF} op_t;

    state_t      r_state;
    op_t         r_op;

    logic [7:0]  r_fifo [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0] r_count;
    logic        r_overrun;

    logic [6:0]  r_cur_x;
    logic [5:0]  r_cur_y;
    logic        r_fb_we;
    logic [12:0] r_fb_addr;
    logic [6:0]  r_fb_data;
    logic [12:0] r_clr_end;
    logic        r_clr_home;

    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic [7:0]  w_head;
    logic [7:0]  w_fold;
    logic        w_print;
    logic [6:0]  w_glyph;
    logic [5:0]  w_next_y;
    logic [12:0] w_row_base;
    logic [12:0] w_next_base;

    function automatic logic [12:0] row_base(input logic [5:0] y);
        return 13'(y) * COLS13;
    endfunction

    assign w_full  = (r_count == DEPTH_CNT);
    assign w_push  = i_wr_stb && !w_full;
    assign w_pop   = (r_state == S_POP);
    assign w_head  = r_fifo[r_rd_ptr];

    // Lowercase folds onto uppercase; printable range is then 0x20-0x5F.
    assign w_fold  = (w_head >= 8'h61 && w_head <= 8'h7A) ? (w_head - 8'h20) : w_head;
    assign w_print = (w_fold >= 8'h20) && (w_fold <= 8'h5F);
    assign w_glyph = 7'(w_fold - 8'h20);

    assign w_next_y    = (r_cur_y == LAST_ROW) ? 6'd0 : (r_cur_y + 6'd1);
    assign w_row_base  = row_base(r_cur_y);
    assign w_next_base = row_base(w_next_y);

    // FIFO storage has no reset; only the pointers/count need defined values.
    always_ff @(posedge i_clk_sys) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= i_data_in;
        end
    end

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (i_wr_stb && w_full) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Write command is prepared while popping so that FB_WE is a registered
    // output that is high for exactly the EXEC cycle.
    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_op       <= OP_NONE;
            r_cur_x    <= '0;
            r_cur_y    <= '0;
            r_fb_we    <= 1'b0;
            r_fb_addr  <= '0;
            r_fb_data  <= '0;
            r_clr_end  <= '0;
            r_clr_home <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_fb_we <= 1'b0;
                    if (r_count != '0) begin
                        r_state <= S_POP;
                    end
                end

                S_POP: begin
                    r_state <= S_EXEC;
                    r_fb_we <= 1'b0;
                    if (w_print) begin
                        r_op      <= OP_PRINT;
                        r_fb_we   <= 1'b1;
                        r_fb_addr <= w_row_base + 13'(r_cur_x);
                        r_fb_data <= w_glyph;
                    end else begin
                        case (w_head)
                            8'h0D:   r_op <= OP_CR;
                            8'h0A:   r_op <= OP_LF;
                            8'h0C:   r_op <= OP_FF;
                            8'h08: begin
                                r_op <= OP_BS;
                                if (r_cur_x != '0) begin
                                    r_fb_we   <= 1'b1;
                                    r_fb_addr <= w_row_base + 13'(r_cur_x - 7'd1);
                                    r_fb_data <= '0;
                                end
                            end
                            default: r_op <= OP_NONE;
                        endcase
                    end
                end

                S_EXEC: begin
                    r_state <= S_IDLE;
                    r_fb_we <= 1'b0;
                    case (r_op)
                        OP_PRINT, OP_LF: begin
                            if (r_op == OP_PRINT && r_cur_x != LAST_COL) begin
                                r_cur_x <= r_cur_x + 7'd1;
                            end else begin
                                r_cur_x <= '0;
                                r_cur_y <= w_next_y;
`ifdef LINE_CLEAR_EN
                                r_state    <= S_CLEAR;
                                r_fb_we    <= 1'b1;
                                r_fb_addr  <= w_next_base;
                                r_fb_data  <= '0;
                                r_clr_end  <= w_next_base + COLS13 - 13'd1;
                                r_clr_home <= 1'b0;
`endif
                            end
                        end
                        OP_CR: r_cur_x <= '0;
                        OP_BS: begin
                            if (r_cur_x != '0) begin
                                r_cur_x <= r_cur_x - 7'd1;
                            end
                        end
                        OP_FF: begin
                            r_state    <= S_CLEAR;
                            r_fb_we    <= 1'b1;
                            r_fb_addr  <= '0;
                            r_fb_data  <= '0;
                            r_clr_end  <= LAST_CELL;
                            r_clr_home <= 1'b1;
                        end
                        default: ;
                    endcase
                end

                S_CLEAR: begin
                    if (r_fb_addr == r_clr_end) begin
                        r_state <= S_IDLE;
                        r_fb_we <= 1'b0;
                        if (r_clr_home) begin
                            r_cur_x <= '0;
                            r_cur_y <= '0;
                        end
                    end else begin
                        r_fb_addr <= r_fb_addr + 13'd1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Unused in the default build; keeps the next-row base referenced.
    logic w_unused;
    assign w_unused = ^w_next_base;

    assign o_full     = w_full;
    assign o_busy     = (r_count != '0) || (r_state != S_IDLE);
    assign o_overrun  = r_overrun;
    assign o_fb_we    = r_fb_we;
    assign o_fb_addr  = r_fb_addr;
    assign o_fb_data  = r_fb_data;
    assign o_cursor_x = r_cur_x;
    assign o_cursor_y = r_cur_y;

endmodule

// File: tb/tb_text_console_ctrl.sv
module tb_text_console_ctrl;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        wr_stb = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        full, busy, overrun, fb_we;
    logic [12:0] fb_addr;
    logic [6:0]  fb_data;
    logic [6:0]  cursor_x;
    logic [5:0]  cursor_y;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [12:0] q_addr[$];
    logic [6:0]  q_data[$];
    int          q_cyc[$];

    text_console_ctrl dut (
        .i_clk_sys (clk_sys),
        .i_rst     (rst),
        .i_wr_stb  (wr_stb),
        .i_data_in (data_in),
        .o_full    (full),
        .o_busy    (busy),
        .o_overrun (overrun),
        .o_fb_we   (fb_we),
        .o_fb_addr (fb_addr),
        .o_fb_data (fb_data),
        .o_cursor_x(cursor_x),
        .o_cursor_y(cursor_y)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc++;

    always @(negedge clk_sys) begin
        if (fb_we) begin
            q_addr.push_back(fb_addr);
            q_data.push_back(fb_data);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_stb = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1 rst = 1'b0;
        clear_log();
    endtask

    // Strobe is captured at the next rising edge; returns 1 ns after it.
    task automatic strobe(input logic [7:0] b);
        wr_stb = 1'b1;
        data_in = b;
        @(posedge clk_sys);
        #1 wr_stb = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(posedge clk_sys);
            #1 n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic send(input logic [7:0] b);
        strobe(b);
        wait_idle("idle", 6000);
    endtask

    initial begin
        int bad;

        // Reset values
        #1;
        check("rst_we", fb_we, 0);
        check("rst_addr", fb_addr, 0);
        check("rst_data", fb_data, 0);
        check("rst_cx", cursor_x, 0);
        check("rst_cy", cursor_y, 0);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", overrun, 0);
        do_reset();

        // 'A' latency: write visible just before edge E+3
        strobe(8'h41);
        check("a_we_e0", fb_we, 0);
        @(posedge clk_sys); #1;
        check("a_we_e1", fb_we, 0);
        @(posedge clk_sys); #1;
        check("a_we_e2", fb_we, 1);
        check("a_addr", fb_addr, 0);
        check("a_data", fb_data, 7'h21);
        check("a_cx_pre", cursor_x, 0);
        @(posedge clk_sys); #1;
        check("a_we_e3", fb_we, 0);
        check("a_cx", cursor_x, 1);
        check("a_cy", cursor_y, 0);
        check("a_busy", busy, 0);

        // Lowercase fold
        clear_log();
        send(8'h61);
        check("lc_n", q_addr.size(), 1);
        if (q_addr.size() == 1) begin
            check("lc_addr", q_addr[0], 1);
            check("lc_data", q_data[0], 7'h21);
        end
        check("lc_cx", cursor_x, 2);

        // Discarded byte, BUSY falls after 3 cycles
        clear_log();
        strobe(8'h7F);
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1;
        check("del_busy_e2", busy, 1);
        @(posedge clk_sys); #1;
        check("del_busy_e3", busy, 0);
        check("del_n", q_addr.size(), 0);
        check("del_cx", cursor_x, 2);

        // Full row of '.' with auto-wrap
        do_reset();
        for (int i = 0; i < 80; i++) send(8'h2E);
`ifdef LINE_CLEAR_EN
        check("row_n", q_addr.size(), 160);
`else
        check("row_n", q_addr.size(), 80);
`endif
        bad = 0;
        for (int i = 0; i < q_addr.size(); i++) begin
            if (q_addr[i] != 13'(i)) bad++;
            if (q_data[i] != ((i < 80) ? 7'h0E : 7'h00)) bad++;
        end
        check("row_bad", bad, 0);
        check("row_cx", cursor_x, 0);
        check("row_cy", cursor_y, 1);

        // Bottom row wrap via LF
        for (int i = 0; i < 58; i++) send(8'h0A);
        check("bot_cy", cursor_y, 59);
        clear_log();
        send(8'h0A);
        check("wrap_cx", cursor_x, 0);
        check("wrap_cy", cursor_y, 0);
`ifdef LINE_CLEAR_EN
        check("wrap_n", q_addr.size(), 80);
        bad = 0;
        for (int i = 0; i < q_addr.size(); i++)
            if (q_addr[i] != 13'(i) || q_data[i] != 7'h00) bad++;
        check("wrap_bad", bad, 0);
`else
        check("wrap_n", q_addr.size(), 0);
`endif

        // Backspace
        do_reset();
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h20);
        check("bs_pre_cx", cursor_x, 5);
        check("bs_pre_cy", cursor_y, 2);
        clear_log();
        send(8'h08);
        check("bs_n", q_addr.size(), 1);
        if (q_addr.size() == 1) begin
            check("bs_addr", q_addr[0], 164);
            check("bs_data", q_data[0], 0);
        end
        check("bs_cx", cursor_x, 4);
        check("bs_cy", cursor_y, 2);
        send(8'h0D);
        check("cr_cx", cursor_x, 0);
        clear_log();
        send(8'h08);
        check("bs0_n", q_addr.size(), 0);
        check("bs0_cx", cursor_x, 0);
        check("bs0_cy", cursor_y, 2);

        // Form feed with bytes queued during the clear
        do_reset();
        strobe(8'h0C);
        for (int i = 0; i < 8; i++) strobe(8'h41 + 8'(i));
        check("ff_ovr_8", overrun, 0);
        check("ff_full_8", full, 1);
        strobe(8'h49);
        check("ff_ovr_9", overrun, 1);
        check("ff_full_9", full, 1);
        repeat (2000) @(posedge clk_sys);
        #1;
        check("ff_full_mid", full, 1);
        check("ff_we_mid", fb_we, 1);
        wait_idle("ff_idle", 6000);
        check("ff_n", q_addr.size(), 4808);
        bad = 0;
        if (q_addr.size() == 4808) begin
            for (int i = 0; i < 4800; i++) begin
                if (q_addr[i] != 13'(i) || q_data[i] != 7'h00) bad++;
                if (i > 0 && q_cyc[i] != q_cyc[i-1] + 1) bad++;
            end
            for (int i = 0; i < 8; i++)
                if (q_addr[4800+i] != 13'(i) || q_data[4800+i] != 7'(8'h21 + i)) bad++;
        end
        check("ff_bad", bad, 0);
        check("ff_cx", cursor_x, 8);
        check("ff_cy", cursor_y, 0);
        check("ff_full_end", full, 0);
        check("ff_ovr_end", overrun, 1);

        // Reset mid-clear drops FB_WE without a clock edge
        strobe(8'h0C);
        repeat (100) @(posedge clk_sys);
        @(negedge clk_sys);
        check("arst_we_pre", fb_we, 1);
        rst = 1'b1;
        #1;
        check("arst_we", fb_we, 0);
        check("arst_ovr", overrun, 0);
        check("arst_busy", busy, 0);
        #20 rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
